// File: rtl/axilite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed memory with byte-strobe writes.
// The write (AW/W/B) and read (AR/R) paths are independent FSMs that run concurrently.
module axilite_slave_mem #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000_0000
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [2:0]          s_awprot,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [2:0]          s_arprot,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready
);
    localparam int                STRB_W      = DATA_W / 8;
    localparam int                IDX_LSB     = $clog2(STRB_W);
    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(DEPTH * STRB_W);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_RESP} rstate_e;

    wstate_e             wstate_q, wstate_d;
    rstate_e             rstate_q, rstate_d;
    logic                aw_full_q, aw_full_d;
    logic                w_full_q, w_full_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Offset wraps modulo 2^ADDR_W, so addresses below the base land out of range.
    logic [ADDR_W-1:0]   w_off, r_off;
    logic                w_in_range, r_in_range;
    logic [IDX_W-1:0]    w_idx, r_idx;

    assign w_off      = awaddr_q - BASE_ADDR;
    assign r_off      = araddr_q - BASE_ADDR;
    assign w_in_range = w_off < SPAN;
    assign r_in_range = r_off < SPAN;
    assign w_idx      = w_off[IDX_LSB +: IDX_W];
    assign r_idx      = r_off[IDX_LSB +: IDX_W];

    logic unused_ok;
    assign unused_ok = ^{s_awprot, s_arprot, w_off, r_off};

    always_comb begin
        wstate_d  = wstate_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s_awvalid && awready_q) begin
                    aw_full_d = 1'b1;
                    awaddr_d  = s_awaddr;
                end
                if (s_wvalid && wready_q) begin
                    w_full_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if (aw_full_d && w_full_d) wstate_d = W_COMMIT;
            end
            W_COMMIT: begin
                mem_we   = w_in_range;
                bvalid_d = 1'b1;
                bresp_d  = w_in_range ? RESP_OKAY : RESP_SLVERR;
                wstate_d = W_RESP;
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        // Readies are registered: each reflects whether its slot will be free next cycle.
        awready_d = (wstate_d == W_IDLE) && !aw_full_d;
        wready_d  = (wstate_d == W_IDLE) && !w_full_d;
    end

    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_arvalid && arready_q) begin
                    araddr_d = s_araddr;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                rdata_d  = r_in_range ? mem[r_idx] : '0;
                rresp_d  = r_in_range ? RESP_OKAY : RESP_SLVERR;
                rvalid_d = 1'b1;
                rstate_d = R_RESP;
            end
            R_RESP: begin
                if (s_rready) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory is never cleared; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge aclk) begin
        if (aresetn && mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
endmodule

// File: tb/tb_axilite_slave_mem.sv
// Bench for axilite_slave_mem: directed vector table, hand-written corner sequences,
// and randomized traffic checked against an array-based memory model.
module tb_axilite_slave_mem;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 1024;
    localparam int          STRB_W = 8;
    localparam logic [31:0] BASE   = 32'h1000_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic [2:0]  s_awprot = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [2:0]  s_arprot = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    axilite_slave_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [DEPTH];

    typedef struct {
        logic [31:0] waddr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          w_early;
        int          stall;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [63:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected handshake within bound", name);
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * STRB_W);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 32'(STRB_W));
    endfunction

    function automatic logic [63:0] m_merge(input logic [63:0] old, input logic [63:0] d,
                                            input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Called just after a negedge. w_early > 0: W leads AW by that many cycles; < 0: AW leads.
    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int w_early, input int stall, input logic [1:0] exp_resp,
                             input string tag);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int t = 0, lat = 0;
        int w_lead = (w_early > 0) ? w_early : 0;
        int aw_lead = (w_early < 0) ? -w_early : 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = (w_lead == 0);
        s_wvalid = (aw_lead == 0);
        while (!(aw_done && w_done)) begin
            hs_aw = s_awvalid && s_awready;
            hs_w = s_wvalid && s_wready;
            @(negedge aclk);
            t++;
            if (hs_aw) begin aw_done = 1; s_awvalid = 1'b0; end
            if (hs_w) begin w_done = 1; s_wvalid = 1'b0; end
            if (!aw_done && t >= w_lead) s_awvalid = 1'b1;
            if (!w_done && t >= aw_lead) s_wvalid = 1'b1;
            if (t > 50) begin
                s_awvalid = 1'b0; s_wvalid = 1'b0;
                timeout_fail({tag, " aw/w handshake"});
                return;
            end
        end
        while (!s_bvalid && lat < 20) begin @(negedge aclk); lat++; end
        if (!s_bvalid) begin timeout_fail({tag, " bvalid"}); return; end
        check({tag, " b latency"}, 64'(lat), 64'd1);
        check({tag, " bresp"}, 64'(s_bresp), 64'(exp_resp));
        for (int k = 0; k < stall; k++) begin
            @(negedge aclk);
            check({tag, " stall bvalid/bresp"}, 64'({s_bvalid, s_bresp}), 64'({1'b1, exp_resp}));
            check({tag, " stall aw/w ready"}, 64'({s_awready, s_wready}), 64'd0);
        end
        s_bready = 1'b1;
        @(negedge aclk);
        s_bready = 1'b0;
        check({tag, " b done"}, 64'({s_bvalid, s_awready, s_wready}), 64'b011);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [63:0] exp_data,
                            input logic [1:0] exp_resp, input int stall, input string tag);
        bit done = 0, hs;
        int t = 0, lat = 0;
        s_araddr = a;
        s_arvalid = 1'b1;
        while (!done) begin
            hs = s_arvalid && s_arready;
            @(negedge aclk);
            t++;
            if (hs) begin done = 1; s_arvalid = 1'b0; end
            if (t > 50) begin s_arvalid = 1'b0; timeout_fail({tag, " ar handshake"}); return; end
        end
        while (!s_rvalid && lat < 20) begin @(negedge aclk); lat++; end
        if (!s_rvalid) begin timeout_fail({tag, " rvalid"}); return; end
        check({tag, " r latency"}, 64'(lat), 64'd1);
        check({tag, " rdata"}, s_rdata, exp_data);
        check({tag, " rresp"}, 64'(s_rresp), 64'(exp_resp));
        for (int k = 0; k < stall; k++) begin
            @(negedge aclk);
            check({tag, " stall rvalid/rresp"}, 64'({s_rvalid, s_rresp}), 64'({1'b1, exp_resp}));
            check({tag, " stall rdata"}, s_rdata, exp_data);
            check({tag, " stall arready"}, 64'(s_arready), 64'd0);
        end
        s_rready = 1'b1;
        @(negedge aclk);
        s_rready = 1'b0;
        check({tag, " r done"}, 64'({s_rvalid, s_arready}), 64'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h1000_0040, 64'h0000_0000_8765_4321, 8'hFF, 0, 0, 2'b00,
                     32'h1000_0040, 64'h0000_0000_8765_4321, 2'b00};
        vecs[1]  = '{32'h1000_0C80, 64'h0, 8'hFF, 0, 0, 2'b00,
                     32'h1000_0C80, 64'h0, 2'b00};
        vecs[2]  = '{32'h1000_0C80, 64'hDEAD_BEEF_1234_5678, 8'h0F, 0, 0, 2'b00,
                     32'h1000_0C80, 64'h0000_0000_1234_5678, 2'b00};
        vecs[3]  = '{32'h1000_0C80, 64'hFFFF_FFFF_0000_0000, 8'hF0, 3, 0, 2'b00,
                     32'h1000_0C80, 64'hFFFF_FFFF_1234_5678, 2'b00};
        vecs[4]  = '{32'h1000_0C80, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, -2, 0, 2'b00,
                     32'h1000_0C80, 64'hFFFF_FFFF_1234_5678, 2'b00};
        vecs[5]  = '{32'h3000_0000, 64'h5555_5555_5555_5555, 8'hFF, 0, 0, 2'b10,
                     32'h3000_0000, 64'h0, 2'b10};
        vecs[6]  = '{32'h3000_0040, 64'h5555_5555_5555_5555, 8'hFF, 1, 0, 2'b10,
                     32'h1000_0040, 64'h0000_0000_8765_4321, 2'b00};
        vecs[7]  = '{32'h0FFF_FFF8, 64'h1, 8'hFF, 0, 0, 2'b10,
                     32'h0FFF_FFF8, 64'h0, 2'b10};
        vecs[8]  = '{32'h1000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, -1, 0, 2'b00,
                     32'h1000_1FFF, 64'h0123_4567_89AB_CDEF, 2'b00};
        vecs[9]  = '{32'h1000_2000, 64'h2, 8'hFF, 0, 0, 2'b10,
                     32'h1000_2000, 64'h0, 2'b10};
        vecs[10] = '{32'h1000_0087, 64'h1111_2222_3333_4444, 8'hFF, 1, 0, 2'b00,
                     32'h1000_0080, 64'h1111_2222_3333_4444, 2'b00};
        vecs[11] = '{32'h1000_0040, 64'h0000_0000_8765_4321, 8'hFF, 0, 10, 2'b00,
                     32'h1000_0040, 64'h0000_0000_8765_4321, 2'b00};

        // Reset with awvalid asserted: everything must stay quiet.
        s_awvalid = 1'b1;
        repeat (4) @(negedge aclk);
        check("reset outputs", {s_awready, s_wready, s_arready, s_bvalid, s_bresp,
                                s_rvalid, s_rresp, s_rdata}, 64'd0);
        s_awvalid = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        check("reset release readys/bvalid", 64'({s_awready, s_wready, s_arready, s_bvalid}),
              64'b1110);

        for (int v = 0; v < 12; v++) begin
            axi_write(vecs[v].waddr, vecs[v].wdata, vecs[v].wstrb, vecs[v].w_early,
                      vecs[v].stall, vecs[v].bresp, $sformatf("vec%0d wr", v));
            axi_read(vecs[v].raddr, vecs[v].rdata, vecs[v].rresp, vecs[v].stall,
                     $sformatf("vec%0d rd", v));
        end

        // Commit and read sample of the same word on the same edge: read sees old data.
        s_awaddr = 32'h1000_0080; s_wdata = 64'hCAFE_F00D_0000_0001; s_wstrb = 8'hFF;
        s_araddr = 32'h1000_0080;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        check("same-edge readys", 64'({s_awready, s_wready, s_arready}), 64'b111);
        @(negedge aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge aclk);
        check("same-edge valids", 64'({s_bvalid, s_rvalid}), 64'b11);
        check("same-edge old rdata", s_rdata, 64'h1111_2222_3333_4444);
        @(negedge aclk);
        s_bready = 1'b0; s_rready = 1'b0;
        check("same-edge done", 64'({s_bvalid, s_rvalid}), 64'b00);
        axi_read(32'h1000_0080, 64'hCAFE_F00D_0000_0001, 2'b00, 0, "same-edge reread");

        // Reset one cycle after the AW/W handshake drops the write entirely.
        s_awaddr = 32'h1000_0040; s_wdata = 64'hBAD0_BAD0_BAD0_BAD0; s_wstrb = 8'hFF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst outputs", {s_awready, s_wready, s_arready, s_bvalid, s_bresp,
                                 s_rvalid, s_rresp, s_rdata}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("midrst release", 64'({s_awready, s_wready, s_arready, s_bvalid}), 64'b1110);
        repeat (3) @(negedge aclk);
        check("midrst no bvalid", 64'(s_bvalid), 64'd0);
        axi_read(32'h1000_0040, 64'h0000_0000_8765_4321, 2'b00, 0, "midrst read");

        // Randomized traffic on a 16-word window plus stray out-of-range addresses.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            logic [63:0] d;
            a = 32'h1000_0100 + 32'(k * 8);
            d = {$urandom, $urandom};
            model[m_idx(a)] = d;
            axi_write(a, d, 8'hFF, 0, 0, 2'b00, "rnd fill");
        end
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [63:0] d;
            logic [7:0]  s;
            bit          inr;
            int          we;
            if ($urandom_range(0, 6) == 0) begin
                a = $urandom;
                if (m_in_range(a)) a = 32'h3000_0000 | (a & 32'h0000_0FFF);
            end else begin
                a = 32'h1000_0100 + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
            end
            d = {$urandom, $urandom};
            s = 8'($urandom);
            we = int'($urandom_range(0, 6)) - 3;
            inr = m_in_range(a);
            if ($urandom_range(0, 1) == 0) begin
                axi_write(a, d, s, we, int'($urandom_range(0, 2)), inr ? 2'b00 : 2'b10,
                          $sformatf("rnd%0d wr %h", n, a));
                if (inr) model[m_idx(a)] = m_merge(model[m_idx(a)], d, s);
            end else begin
                axi_read(a, inr ? model[m_idx(a)] : 64'd0, inr ? 2'b00 : 2'b10,
                         int'($urandom_range(0, 2)), $sformatf("rnd%0d rd %h", n, a));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
